load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port: accepts one load/store request at a time from the execute stage over a valid/ready handshake and drives the `data_mem` port (`we`, `re`, `addr`, `data`, `mem_size`). It returns sign- or zero-extended load data, or a write acknowledge, over a second valid/ready handshake to writeback. Misaligned accesses are split into byte accesses or faulted, selected by a compile-time option.

## Interface
- `AddrWidth`, default 32: request and memory address width; addresses wrap modulo 2^AddrWidth.
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst`  in  1  reset; synchronous, active-low.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  LSU can accept a request.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_addr`  in  AddrWidth  byte address.
- `i_req_wdata`  in  32  store data, LSB-aligned.
- `i_req_size`  in  `mem_op_sz_e`  access size: BYTE, HWORD or WORD.
- `i_req_unsigned`  in  1  load zero-extends when 1 and sign-extends when 0; ignored for WORD and stores.
- `o_mem_we`, `o_mem_re`  out  1  memory write and read enables.
- `o_mem_addr`  out  32  memory byte address.
- `o_mem_wdata`  out  32  memory write data.
- `o_mem_size`  out  `mem_op_sz_e`  memory access size.
- `i_mem_rdata`  in  32  memory read data; combinational in the same cycle as the address.
- `o_rsp_valid`  out  1  response present.
- `i_rsp_ready`  in  1  consumer accepts the response.
- `o_rsp_rdata`  out  32  extended load data; 0 for stores and faults.
- `o_rsp_err`  out  1  misaligned access or illegal size fault.

## Operation
- **States (`lsu_state_e`):** IDLE, ACCESS, SPLIT, RESP.
- **Ready:** `o_req_ready` = (state == IDLE). A request is accepted on a cycle with `i_req_valid && o_req_ready`; all request fields are registered on that edge.
- **Alignment:** a request is misaligned when it is HWORD with `addr[0]` = 1, or WORD with `addr[1:0]` ≠ 0.
- **Illegal size:** a size encoding other than BYTE, HWORD or WORD → state RESP with `err` = 1 and no memory access.
- **IDLE → ACCESS:** taken for an aligned request.
- **ACCESS:**
  - Drives the memory port for exactly one cycle with the registered address, size and data, and `we` = store, `re` = load.
  - For loads, `i_mem_rdata` is captured and extended into the response register.
  - Then → RESP.
- **Misaligned request:** with the macro → SPLIT; without it → RESP with `err` = 1 and no memory access.
- **SPLIT:**
  - Performs n byte accesses (n = 2 for HWORD, 4 for WORD), one per cycle, at `addr + k` for k = 0..n−1, with `o_mem_size` = BYTE.
  - Stores: byte k of `wdata` is written to `addr + k`.
  - Loads: the byte read at `addr + k` is placed in result bits [8k+7:8k].
  - After byte n−1 → RESP.
- **Load extension:** BYTE sign-extends from bit 7 and HWORD from bit 15 when `unsigned` = 0; both zero-extend when `unsigned` = 1.
- **RESP:** `o_rsp_valid` = 1 and the response fields are held stable until `i_rsp_ready`; on acceptance → IDLE.
- **Memory port outside ACCESS/SPLIT:** `we` = `re` = 0, `addr` = 0, `wdata` = 0, `size` = BYTE.
- **Reset:**
  - All state returns to IDLE. `o_rsp_valid`, `o_rsp_err`, `o_rsp_rdata` and all memory outputs go to 0, with `size` = BYTE; `o_req_ready` = 1 after reset.
  - Reset mid-SPLIT abandons the access; bytes already written remain in memory.
- **Address wrap:** addresses computed as `addr + k` wrap modulo 2^AddrWidth (e.g. `0xFFFFFFFF` + 1 = `0x0`).

## Timing
- **Aligned access:** request accepted at edge N; ACCESS occupies cycle N+1 (a store commits at edge N+2); `o_rsp_valid` rises in cycle N+2.
- **Split access:** `o_rsp_valid` rises in cycle N+1+n.
- **Faulted request:** `o_rsp_valid` rises in cycle N+1.
- **Throughput:** at most one outstanding request. If the response is accepted in cycle R, the next request can be accepted in cycle R+1.
- **Memory outputs:** driven from registered state only; no combinational path from `i_req_*` to `o_mem_*`.

## Configuration
- **Macro `LSU_MISALIGNED_EN`.**
- **Defined:** misaligned HWORD/WORD requests are split into byte accesses with no fault (`err` = 0).
- **Undefined:** SPLIT is not compiled in, and misaligned requests respond with `err` = 1, `rdata` = 0 and no memory enable asserted.

## Structure
- **`rv_pkg`:** add the `lsu_state_e` enum; reuse the existing `mem_op_sz_e`.
- **Sub-module `lsu_load_ext`:** combinational size/sign extension (inputs: raw 32-bit data, size, unsigned; output: 32-bit result). Instantiated once.

## Test plan
- **Aligned signed byte load:** memory[0x5] = 0x80; load BYTE `unsigned` = 0 at 0x5 → `rdata` `0xFFFFFF80`, `err` = 0, `valid` in cycle N+2.
- **Aligned word store then load:** store WORD `0xDEADBEEF` at 0x4, then load WORD at 0x4 → `0xDEADBEEF`; bytes 0x4..0x7 = EF, BE, AD, DE.
- **Misaligned load, macro defined:** memory bytes 0x1..0x4 = 11, 22, 33, 44; load WORD at 0x1 → `0x44332211`, four BYTE accesses at 0x1..0x4, `valid` in cycle N+5.
- **Misaligned store, macro undefined:** store HWORD at 0x3 → `err` = 1, `rdata` = 0, `o_mem_we` never asserted, `valid` in cycle N+1.
- **Response backpressure:** hold `i_rsp_ready` = 0 for 5 cycles in RESP → `valid`/`rdata` stable and `o_req_ready` = 0 throughout; accept → next request taken the following cycle.
- **Reset mid-split:** assert reset during the SPLIT of a WORD store at 0x2 after 2 byte writes → state IDLE, `o_rsp_valid` = 0, bytes 0x2 and 0x3 written, 0x4 and 0x5 unchanged.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared memory-access size and load/store unit state types.
package rv_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HWORD = 2'd1, WORD = 2'd2} mem_op_sz_e;
  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} lsu_state_e;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, data-memory and response bundle of the load/store unit.
interface load_store_unit_if #(parameter int AddrWidth = 32);
  import rv_pkg::*;
  logic                 i_req_valid;
  logic                 o_req_ready;
  logic                 i_req_we;
  logic [AddrWidth-1:0] i_req_addr;
  logic [31:0]          i_req_wdata;
  mem_op_sz_e           i_req_size;
  logic                 i_req_unsigned;
  logic                 o_mem_we;
  logic                 o_mem_re;
  logic [31:0]          o_mem_addr;
  logic [31:0]          o_mem_wdata;
  mem_op_sz_e           o_mem_size;
  logic [31:0]          i_mem_rdata;
  logic                 o_rsp_valid;
  logic                 i_rsp_ready;
  logic [31:0]          o_rsp_rdata;
  logic                 o_rsp_err;
  modport master (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
           i_mem_rdata, i_rsp_ready,
    output o_req_ready, o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata, o_mem_size,
           o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
  modport slave (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
           i_mem_rdata, i_rsp_ready,
    input  o_req_ready, o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata, o_mem_size,
           o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/load_store_unit_load_ext.sv
// lsu_load_ext: sign/zero extension of raw load data by access size.
module lsu_load_ext
  import rv_pkg::*;
(
  input  logic [31:0] data_i,
  input  mem_op_sz_e  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);
  assign data_o = size_i == BYTE  ? {{24{!uns_i && data_i[7]}}, data_i[7:0]} :
                  size_i == HWORD ? {{16{!uns_i && data_i[15]}}, data_i[15:0]} : data_i;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator on the data-memory port.
// Define LSU_MISALIGNED_EN to split misaligned accesses into byte accesses instead of faulting.
module load_store_unit
  import rv_pkg::*;
#(parameter int AddrWidth = 32) (
  input logic                i_clk,
  input logic                i_rst,
  load_store_unit_if.master  bus
);
  lsu_state_e           state_q, state_d;
  logic                 we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [AddrWidth-1:0] addr_q, addr_d, mem_addr;
  logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d, ext_in, ext_out;
  mem_op_sz_e           size_q, size_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 legal, misaligned, act;
  assign legal      = bus.i_req_size inside {BYTE, HWORD, WORD};
  assign misaligned = (bus.i_req_size == HWORD && bus.i_req_addr[0]) ||
                      (bus.i_req_size == WORD && bus.i_req_addr[1:0] != 2'b00);
  assign mem_addr   = addr_q + AddrWidth'(cnt_q);
  // Memory enables also drop while reset is held so an abandoned split writes no further byte
  assign act             = i_rst && (state_q == ACCESS || state_q == SPLIT);
  assign bus.o_mem_we    = act && we_q;
  assign bus.o_mem_re    = act && !we_q;
  assign bus.o_mem_addr  = act ? 32'(mem_addr) : 32'd0;
  assign bus.o_mem_wdata = !act ? 32'd0 : state_q == SPLIT ? {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]} : wdata_q;
  assign bus.o_mem_size  = act && state_q == ACCESS ? size_q : BYTE;
  assign bus.o_req_ready = state_q == IDLE;
  assign bus.o_rsp_valid = state_q == RESP;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = err_q;
  lsu_load_ext u_ext (.data_i(ext_in), .size_i(size_q), .uns_i(uns_q), .data_o(ext_out));
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ext_in  = bus.i_mem_rdata;
    case (state_q)
      IDLE: if (bus.i_req_valid) begin
        we_d    = bus.i_req_we;
        uns_d   = bus.i_req_unsigned;
        addr_d  = bus.i_req_addr;
        wdata_d = bus.i_req_wdata;
        size_d  = bus.i_req_size;
        cnt_d   = 2'd0;
        rdata_d = 32'd0;
`ifdef LSU_MISALIGNED_EN
        err_d   = !legal;
        state_d = !legal ? RESP : misaligned ? SPLIT : ACCESS;
`else
        err_d   = !legal || misaligned;
        state_d = !legal || misaligned ? RESP : ACCESS;
`endif
      end
      ACCESS: begin
        rdata_d = we_q ? rdata_q : ext_out;
        state_d = RESP;
      end
`ifdef LSU_MISALIGNED_EN
      SPLIT: begin
        ext_in = rdata_q;
        ext_in[{cnt_q, 3'b000} +: 8] = bus.i_mem_rdata[7:0];
        rdata_d = we_q ? rdata_q : ext_out;
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == (size_q == HWORD ? 2'd1 : 2'd3) ? RESP : SPLIT;
      end
`endif
      RESP: state_d = bus.i_rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= BYTE;
      cnt_q   <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit; exercises LSU_MISALIGNED_EN when defined.
module tb_load_store_unit;
  import rv_pkg::*;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          vcyc;
  } exp_t;
  logic        clk, rst;
  int          cyc = 0, checks = 0, failures = 0, pop_cyc = 0, accept_cyc = 0, acc_cnt = 0, n0;
  logic        prev_valid;
  exp_t        exp_q[$];
  logic [7:0]  mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_addr, ra;
  logic [7:0]  pl_data;
  logic [31:0] last_addr;
  mem_op_sz_e  last_size;
  int          nb;
  load_store_unit_if #(.AddrWidth(32)) bus();
  load_store_unit #(.AddrWidth(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.master));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Byte-addressed memory model: LSB-aligned read data, little-endian multi-byte writes
  assign ra = bus.o_mem_addr[5:0];
  assign bus.i_mem_rdata = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};
  assign nb = bus.o_mem_size == BYTE ? 1 : bus.o_mem_size == HWORD ? 2 : 4;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.o_mem_we)
      for (int k = 0; k < 4; k++)
        if (k < nb) mem[ra + 6'(k)] <= bus.o_mem_wdata[8*k +: 8];
    if (bus.o_mem_we || bus.o_mem_re) begin
      acc_cnt   <= acc_cnt + 1;
      last_addr <= bus.o_mem_addr;
      last_size <= bus.o_mem_size;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) prev_valid <= 1'b0;
    else begin
      prev_valid <= bus.o_rsp_valid;
      if (bus.o_rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", exp_q.size(), 1);
        else begin
          if (!prev_valid) chk("rsp_latency", cyc, exp_q[0].vcyc);
          chk("rsp_rdata", bus.o_rsp_rdata, exp_q[0].rdata);
          chk("rsp_err", {31'd0, bus.o_rsp_err}, {31'd0, exp_q[0].err});
          chk("req_ready_in_resp", {31'd0, bus.o_req_ready}, 32'd0);
          if (bus.i_rsp_ready) begin
            void'(exp_q.pop_front());
            pop_cyc <= cyc;
          end
        end
      end
    end
  end
  task automatic preload(input logic [5:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input mem_op_sz_e sz,
                       input logic u, input logic [31:0] er, input logic ee, input int lat);
    int t = 0;
    bus.i_req_valid = 1'b1; bus.i_req_we = we; bus.i_req_addr = a; bus.i_req_wdata = wd;
    bus.i_req_size = sz; bus.i_req_unsigned = u;
    while (!bus.o_req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_accept", {31'd0, bus.o_req_ready}, 32'd1);
    if (bus.o_req_ready) begin
      @(posedge clk); #1;
      accept_cyc = cyc;
      exp_q.push_back('{er, ee, cyc + lat});
    end
    bus.i_req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || !bus.o_req_ready) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_reached", {31'd0, exp_q.size() == 0 && bus.o_req_ready}, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_addr = '0; bus.i_req_wdata = '0;
    bus.i_req_size = BYTE; bus.i_req_unsigned = 1'b0; bus.i_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.o_rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.o_rsp_rdata, 32'd0);
    chk("rst_mem_en", {30'd0, bus.o_mem_we, bus.o_mem_re}, 32'd0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.o_mem_wdata, 32'd0);
    chk("rst_mem_size", {30'd0, bus.o_mem_size}, {30'd0, BYTE});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, bus.o_req_ready}, 32'd1);
    preload(6'h05, 8'h80); preload(6'h01, 8'h11); preload(6'h02, 8'h22);
    preload(6'h03, 8'h33); preload(6'h04, 8'h44); preload(6'h10, 8'h34);
    preload(6'h11, 8'h92); preload(6'h3F, 8'h7F); preload(6'h00, 8'h01);
    issue(1'b0, 32'h5, 32'h0, BYTE, 1'b0, 32'hFFFF_FF80, 1'b0, 1);
    issue(1'b0, 32'h5, 32'h0, BYTE, 1'b1, 32'h0000_0080, 1'b0, 1);
    issue(1'b0, 32'h10, 32'h0, HWORD, 1'b0, 32'hFFFF_9234, 1'b0, 1);
    issue(1'b0, 32'h10, 32'h0, HWORD, 1'b1, 32'h0000_9234, 1'b0, 1);
    issue(1'b0, 32'hFFFF_FFFF, 32'h0, BYTE, 1'b0, 32'h0000_007F, 1'b0, 1);
    wait_idle();
    n0 = acc_cnt;
`ifdef LSU_MISALIGNED_EN
    issue(1'b0, 32'h1, 32'h0, WORD, 1'b0, 32'h4433_2211, 1'b0, 4);
    wait_idle();
    chk("split_access_count", acc_cnt - n0, 4);
    chk("split_last_addr", last_addr, 32'h4);
    chk("split_last_size", {30'd0, last_size}, {30'd0, BYTE});
    issue(1'b0, 32'hFFFF_FFFF, 32'h0, HWORD, 1'b1, 32'h0000_017F, 1'b0, 2);
    wait_idle();
    chk("split_wrap_addr", last_addr, 32'h0);
`else
    issue(1'b0, 32'h1, 32'h0, WORD, 1'b0, 32'h0, 1'b1, 0);
    issue(1'b0, 32'hFFFF_FFFF, 32'h0, HWORD, 1'b1, 32'h0, 1'b1, 0);
    wait_idle();
    chk("misaligned_no_access", acc_cnt - n0, 0);
`endif
    issue(1'b1, 32'h4, 32'hDEAD_BEEF, WORD, 1'b0, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h4, 32'h0, WORD, 1'b0, 32'hDEAD_BEEF, 1'b0, 1);
    wait_idle();
    chk("store_bytes", {mem[7], mem[6], mem[5], mem[4]}, 32'hDEAD_BEEF);
    n0 = acc_cnt;
`ifdef LSU_MISALIGNED_EN
    issue(1'b1, 32'h3, 32'h0000_A5C3, HWORD, 1'b0, 32'h0, 1'b0, 2);
    wait_idle();
    chk("split_store_bytes", {16'd0, mem[4], mem[3]}, 32'h0000_A5C3);
`else
    issue(1'b1, 32'h3, 32'h0000_A5C3, HWORD, 1'b0, 32'h0, 1'b1, 0);
    wait_idle();
    chk("fault_store_no_access", acc_cnt - n0, 0);
    chk("fault_store_mem", {16'd0, mem[4], mem[3]}, 32'h0000_EF33);
`endif
    n0 = acc_cnt;
    issue(1'b0, 32'h0, 32'h0, mem_op_sz_e'(2'b11), 1'b0, 32'h0, 1'b1, 0);
    wait_idle();
    chk("illegal_no_access", acc_cnt - n0, 0);
    bus.i_rsp_ready = 1'b0;
    issue(1'b0, 32'h5, 32'h0, BYTE, 1'b1, 32'h0000_00BE, 1'b0, 1);
    for (int t = 0; t < 20 && !bus.o_rsp_valid; t++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_seen", {31'd0, bus.o_rsp_valid}, 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid_held", {31'd0, bus.o_rsp_valid}, 32'd1);
      chk("bp_ready_low", {31'd0, bus.o_req_ready}, 32'd0);
    end
    bus.i_rsp_ready = 1'b1;
    issue(1'b0, 32'h10, 32'h0, HWORD, 1'b1, 32'h0000_9234, 1'b0, 1);
    chk("next_accept_cycle", accept_cyc, pop_cyc + 2);
    wait_idle();
`ifdef LSU_MISALIGNED_EN
    preload(6'h02, 8'h00); preload(6'h03, 8'h00); preload(6'h04, 8'h00); preload(6'h05, 8'h00);
    issue(1'b1, 32'h2, 32'h4433_2211, WORD, 1'b0, 32'h0, 1'b0, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
`else
    issue(1'b1, 32'h8, 32'h1234_5678, WORD, 1'b0, 32'h0, 1'b0, 1);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    chk("midrst_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, bus.o_req_ready}, 32'd1);
    chk("midrst_mem_we", {31'd0, bus.o_mem_we}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
`ifdef LSU_MISALIGNED_EN
    chk("midrst_bytes", {mem[5], mem[4], mem[3], mem[2]}, 32'h0000_2211);
`endif
    issue(1'b0, 32'h6, 32'h0, BYTE, 1'b1, 32'h0000_00AD, 1'b0, 1);
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
